// File: rtl/moving_average_stream_checker.sv
// Scoreboard for a moving-average filter: recomputes the expected average of each input
// sample, queues it, and compares it with the filter output stream, then reports a verdict.
//
// state  | meaning
// IDLE   | waiting for start, results cleared
// RUN    | reference model and compare active
// DONE   | target reached, results held
// FAIL   | stopped on first mismatch, results held
module moving_average_stream_checker #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int QDEPTH     = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  target,
  input  logic                  stop_on_err,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_valid,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  chk_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_got,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  busy,
  output logic                  done,
  output logic                  pass
);

  localparam int LOG2N = $clog2(N);
  localparam int SW    = DATA_WIDTH + LOG2N;
  localparam int QAW   = $clog2(QDEPTH);
  localparam logic [QAW:0] QFULL = (QAW+1)'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FAIL} state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  target_q, target_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] win_q [N];
  logic [DATA_WIDTH-1:0] win_d [N];
  logic [SW-1:0]         sum_q, sum_d;
  logic [QAW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QAW:0]          count_q, count_d;
  logic [CNT_WIDTH-1:0]  chk_cnt_q, chk_cnt_d, err_cnt_q, err_cnt_d, fe_idx_q, fe_idx_d;
  logic                  fe_vld_q, fe_vld_d;
  logic [DATA_WIDTH-1:0] fe_got_q, fe_got_d, fe_exp_q, fe_exp_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, mismatch_q, mismatch_d;

  logic [DATA_WIDTH-1:0] q_mem [QDEPTH];
  logic                  q_we;
  logic [SW-1:0]         sum_next;
  logic [DATA_WIDTH-1:0] exp_new, head, cmp_exp;
  logic                  cmp_do, err_inc, active;

  assign head = q_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    stop_d     = stop_q;
    sum_d      = sum_q;
    for (int i = 0; i < N; i++) win_d[i] = win_q[i];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    chk_cnt_d  = chk_cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_vld_d   = fe_vld_q;
    fe_idx_d   = fe_idx_q;
    fe_got_d   = fe_got_q;
    fe_exp_d   = fe_exp_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    mismatch_d = 1'b0;
    q_we       = 1'b0;
    cmp_do     = 1'b0;
    cmp_exp    = '0;
    err_inc    = 1'b0;
    sum_next   = sum_q + SW'(in_data) - SW'(win_q[N-1]);
    exp_new    = DATA_WIDTH'(sum_next >> LOG2N);
    active     = (state_q == S_RUN) && (chk_cnt_q != target_q);

    unique case (state_q)
      S_RUN: begin
        if (active) begin
          // The window advances on every sample, even if its expected value is dropped.
          if (in_valid) begin
            win_d[0] = in_data;
            for (int i = 1; i < N; i++) win_d[i] = win_q[i-1];
            sum_d = sum_next;
          end
          if (in_valid && out_valid) begin
            cmp_do = 1'b1;
            if (count_q == '0) begin
              cmp_exp = exp_new;
            end else begin
              cmp_exp  = head;
              q_we     = 1'b1;
              wr_ptr_d = wr_ptr_q + QAW'(1);
              rd_ptr_d = rd_ptr_q + QAW'(1);
            end
          end else if (in_valid) begin
            if (count_q == QFULL) begin
              ovf_d   = 1'b1;
              err_inc = 1'b1;
            end else begin
              q_we     = 1'b1;
              wr_ptr_d = wr_ptr_q + QAW'(1);
              count_d  = count_q + (QAW+1)'(1);
            end
          end else if (out_valid) begin
            if (count_q == '0) begin
              unf_d     = 1'b1;
              err_inc   = 1'b1;
              chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
              if (!fe_vld_q) begin
                fe_vld_d = 1'b1;
                fe_idx_d = chk_cnt_q;
                fe_got_d = out_data;
                fe_exp_d = '0;
              end
            end else begin
              cmp_do   = 1'b1;
              cmp_exp  = head;
              rd_ptr_d = rd_ptr_q + QAW'(1);
              count_d  = count_q - (QAW+1)'(1);
            end
          end
        end

        if (cmp_do) begin
          chk_cnt_d = chk_cnt_q + CNT_WIDTH'(1);
          if (out_data != cmp_exp) begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            if (!fe_vld_q) begin
              fe_vld_d = 1'b1;
              fe_idx_d = chk_cnt_q;
              fe_got_d = out_data;
              fe_exp_d = cmp_exp;
            end
          end
        end

        if (err_inc && (err_cnt_q != {CNT_WIDTH{1'b1}})) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);

        if (mismatch_d && stop_q)          state_d = S_FAIL;
        else if (chk_cnt_d == target_q)    state_d = S_DONE;
      end
      default: begin
        if (start) begin
          state_d   = S_RUN;
          target_d  = target;
          stop_d    = stop_on_err;
          sum_d     = '0;
          for (int i = 0; i < N; i++) win_d[i] = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          chk_cnt_d = '0;
          err_cnt_d = '0;
          fe_vld_d  = 1'b0;
          fe_idx_d  = '0;
          fe_got_d  = '0;
          fe_exp_d  = '0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      stop_q     <= 1'b0;
      sum_q      <= '0;
      for (int i = 0; i < N; i++) win_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      chk_cnt_q  <= '0;
      err_cnt_q  <= '0;
      fe_vld_q   <= 1'b0;
      fe_idx_q   <= '0;
      fe_got_q   <= '0;
      fe_exp_q   <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      stop_q     <= stop_d;
      sum_q      <= sum_d;
      for (int i = 0; i < N; i++) win_q[i] <= win_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      chk_cnt_q  <= chk_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_vld_q   <= fe_vld_d;
      fe_idx_q   <= fe_idx_d;
      fe_got_q   <= fe_got_d;
      fe_exp_q   <= fe_exp_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (q_we) q_mem[wr_ptr_q] <= exp_new;
  end

  assign mismatch      = mismatch_q;
  assign chk_cnt       = chk_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = fe_idx_q;
  assign first_err_got = fe_got_q;
  assign first_err_exp = fe_exp_q;
  assign overflow      = ovf_q;
  assign underflow     = unf_q;
  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE) || (state_q == S_FAIL);
  assign pass          = (state_q == S_DONE) && (err_cnt_q == '0) && !ovf_q && !unf_q;

endmodule

// File: tb/tb_moving_average_stream_checker.sv
// Directed bench: each run pushes its expected verdict into a queue; a monitor pops and
// compares it when the checker raises done.
module tb_moving_average_stream_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] target = '0;
  logic        stop_on_err = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_valid = 1'b0;
  logic [7:0]  out_data = '0;
  logic        mismatch, overflow, underflow, busy, done, pass;
  logic [15:0] chk_cnt, err_cnt, first_err_idx;
  logic [7:0]  first_err_got, first_err_exp;

  moving_average_stream_checker #(.N(4), .DATA_WIDTH(8), .QDEPTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .target(target), .stop_on_err(stop_on_err),
    .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .mismatch(mismatch), .chk_cnt(chk_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp), .overflow(overflow),
    .underflow(underflow), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] chk, err, idx, got, expv, pss, ovf, unf, mm;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          mm_count = 0;
  logic        done_prev = 1'b0;
  logic [7:0]  ramp_exp [10] = '{8'd0, 8'd2, 8'd7, 8'd15, 8'd25, 8'd35, 8'd45, 8'd55, 8'd65, 8'd75};
  logic [7:0]  in_vec  [32];
  logic [7:0]  out_vec [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mismatch) mm_count++;
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_done: got done=1, expected no pending run");
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_chk_cnt"},  32'(chk_cnt),       e.chk);
        check({e.name, "_err_cnt"},  32'(err_cnt),       e.err);
        check({e.name, "_fe_idx"},   32'(first_err_idx), e.idx);
        check({e.name, "_fe_got"},   32'(first_err_got), e.got);
        check({e.name, "_fe_exp"},   32'(first_err_exp), e.expv);
        check({e.name, "_pass"},     32'(pass),          e.pss);
        check({e.name, "_overflow"}, 32'(overflow),      e.ovf);
        check({e.name, "_underflow"},32'(underflow),     e.unf);
        check({e.name, "_mm_pulses"},32'(mm_count),      e.mm);
      end
      mm_count = 0;
    end
    done_prev = done;
  end

  task automatic expect_run(input string name, input int chk, input int err, input int idx,
                            input int got, input int expv, input int pss, input int ovf,
                            input int unf, input int mm);
    exp_t e;
    e.name = name; e.chk = chk; e.err = err; e.idx = idx; e.got = got; e.expv = expv;
    e.pss = pss; e.ovf = ovf; e.unf = unf; e.mm = mm;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; leaves the checker in RUN with the next edge processing data.
  task automatic start_run(input logic [15:0] tgt, input logic soe);
    start = 1'b1; target = tgt; stop_on_err = soe;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stream(input int n_in, input int n_out, input int out_start);
    int last;
    last = (n_in > out_start + n_out) ? n_in : out_start + n_out;
    for (int c = 0; c < last; c++) begin
      in_valid  = (c < n_in);
      in_data   = (c < n_in) ? in_vec[c] : 8'd0;
      out_valid = (c >= out_start) && (c - out_start < n_out);
      out_data  = out_valid ? out_vec[c - out_start] : 8'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_valid = 1'b0; in_data = '0; out_data = '0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    @(posedge clk); #1;
    if (!seen) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout: got done=0, expected done=1 within 40 cycles", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 10; k++) begin
      in_vec[k]  = 8'(10 * k);
      out_vec[k] = ramp_exp[k];
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_chk_cnt"}, 32'(chk_cnt), 0);
    check({name, "_err_cnt"}, 32'(err_cnt), 0);
    check({name, "_flags"}, 32'({mismatch, overflow, underflow, busy, done, pass}), 0);
    check({name, "_first_err"}, 32'({first_err_idx, first_err_got, first_err_exp}), 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    load_ramp();
    expect_run("ramp", 10, 0, 0, 0, 0, 1, 0, 0, 0);
    start_run(16'd10, 1'b0);
    stream(10, 10, 1);
    wait_done("ramp");

    load_ramp();
    out_vec[4] = 8'd26;
    expect_run("corrupt", 10, 1, 4, 26, 25, 0, 0, 0, 1);
    start_run(16'd10, 1'b0);
    stream(10, 10, 1);
    wait_done("corrupt");

    load_ramp();
    out_vec[3] = 8'd99;
    out_vec[7] = 8'd99;
    expect_run("stop", 4, 1, 3, 99, 15, 0, 0, 0, 1);
    start_run(16'd10, 1'b1);
    stream(10, 10, 1);
    wait_done("stop");
    check("stop_hold_chk_cnt", 32'(chk_cnt), 4);
    check("stop_hold_err_cnt", 32'(err_cnt), 1);

    load_ramp();
    expect_run("overflow", 8, 1, 0, 0, 0, 0, 1, 0, 0);
    start_run(16'd8, 1'b0);
    stream(9, 8, 9);
    wait_done("overflow");

    out_vec[0] = 8'd5;
    expect_run("underflow", 1, 1, 0, 5, 0, 0, 0, 1, 0);
    start_run(16'd1, 1'b0);
    stream(0, 1, 0);
    wait_done("underflow");

    for (int k = 0; k < 4; k++) in_vec[k] = 8'd255;
    out_vec[0] = 8'd63; out_vec[1] = 8'd127; out_vec[2] = 8'd191; out_vec[3] = 8'd255;
    expect_run("width", 4, 0, 0, 0, 0, 1, 0, 0, 0);
    start_run(16'd4, 1'b0);
    stream(4, 4, 1);
    wait_done("width");

    expect_run("target0", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    start_run(16'd0, 1'b0);
    wait_done("target0");

    load_ramp();
    start_run(16'd10, 1'b0);
    stream(4, 3, 1);
    check("midrst_pre_chk_cnt", 32'(chk_cnt), 3);
    #2 rst = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    expect_run("rerun", 10, 0, 0, 0, 0, 1, 0, 0, 0);
    start_run(16'd10, 1'b0);
    stream(10, 10, 1);
    wait_done("rerun");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL pending_runs: got %0d unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
